// File: rtl/mmio_io_responder.sv
// MEM-stage peripheral responder: HEX/LEDR output registers, synchronized and debounced
// KEY/SW inputs, and a sticky key-press/overrun register with write-1-to-clear.
module mmio_io_responder #(
  parameter int unsigned      DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter int unsigned      DEBOUNCE_CYCLES = 16,
  parameter int unsigned      CNT_BITS        = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrt_en,
  input  logic             rd_en,
  input  logic [DBITS-1:0] wdata,
  output logic             io_hit,
  output logic [DBITS-1:0] rdata,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [9:0]       LEDR,
  output logic [15:0]      HEX
);

  localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic hit_hex, hit_ledr, hit_key, hit_sw, hit_kctrl;

  logic [3:0]          key_s1_q, key_s2_q, key_cand_q, key_cand_d, key_stable_q, key_stable_d;
  logic [CNT_BITS-1:0] key_cnt_q, key_cnt_d;
  logic [9:0]          sw_s1_q, sw_s2_q, sw_cand_q, sw_cand_d, sw_stable_q, sw_stable_d;
  logic [CNT_BITS-1:0] sw_cnt_q, sw_cnt_d;

  logic [7:0]       kctrl_q, kctrl_d, kctrl_clr;
  logic [3:0]       key_press;
  logic [15:0]      hex_q, hex_d;
  logic [9:0]       ledr_q, ledr_d;
  logic [DBITS-1:0] rdata_q, rdata_d;

  logic unused_wdata;
  assign unused_wdata = ^wdata[DBITS-1:16];

  assign hit_hex   = (addr == ADDR_HEX);
  assign hit_ledr  = (addr == ADDR_LEDR);
  assign hit_key   = (addr == ADDR_KEY);
  assign hit_sw    = (addr == ADDR_SW);
  assign hit_kctrl = (addr == ADDR_KCTRL);
  assign io_hit    = hit_hex | hit_ledr | hit_key | hit_sw | hit_kctrl;

  // Key synchronizers and candidates reset to the released (raw high) level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1_q     <= 4'hF;
      key_s2_q     <= 4'hF;
      key_cand_q   <= 4'hF;
      key_cnt_q    <= '0;
      key_stable_q <= '0;
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      sw_cand_q    <= '0;
      sw_cnt_q     <= '0;
      sw_stable_q  <= '0;
      kctrl_q      <= '0;
      hex_q        <= '0;
      ledr_q       <= '0;
      rdata_q      <= '0;
    end else begin
      key_s1_q     <= KEY;
      key_s2_q     <= key_s1_q;
      key_cand_q   <= key_cand_d;
      key_cnt_q    <= key_cnt_d;
      key_stable_q <= key_stable_d;
      sw_s1_q      <= SW;
      sw_s2_q      <= sw_s1_q;
      sw_cand_q    <= sw_cand_d;
      sw_cnt_q     <= sw_cnt_d;
      sw_stable_q  <= sw_stable_d;
      kctrl_q      <= kctrl_d;
      hex_q        <= hex_d;
      ledr_q       <= ledr_d;
      rdata_q      <= rdata_d;
    end
  end

  // Key debounce; stable value is inverted so that 1 means pressed.
  always_comb begin
    key_cand_d   = key_cand_q;
    key_cnt_d    = key_cnt_q;
    key_stable_d = key_stable_q;
    if (key_s2_q != key_cand_q) begin
      key_cand_d = key_s2_q;
      key_cnt_d  = '0;
    end else if (key_cnt_q < CntMax) begin
      key_cnt_d = key_cnt_q + 1'b1;
    end else begin
      key_stable_d = ~key_cand_q;
    end
  end

  always_comb begin
    sw_cand_d   = sw_cand_q;
    sw_cnt_d    = sw_cnt_q;
    sw_stable_d = sw_stable_q;
    if (sw_s2_q != sw_cand_q) begin
      sw_cand_d = sw_s2_q;
      sw_cnt_d  = '0;
    end else if (sw_cnt_q < CntMax) begin
      sw_cnt_d = sw_cnt_q + 1'b1;
    end else begin
      sw_stable_d = sw_cand_q;
    end
  end

  // Press edges are taken from the next stable value so KCTRL updates on the same edge.
  // OR-ing the set terms after the clear makes a same-cycle set win over W1C.
  always_comb begin
    key_press    = key_stable_d & ~key_stable_q;
    kctrl_clr    = (wrt_en && hit_kctrl) ? wdata[7:0] : 8'h00;
    kctrl_d[3:0] = key_press | (kctrl_q[3:0] & ~kctrl_clr[3:0]);
    kctrl_d[7:4] = (key_press & kctrl_q[3:0]) | (kctrl_q[7:4] & ~kctrl_clr[7:4]);
  end

  always_comb begin
    hex_d  = hex_q;
    ledr_d = ledr_q;
    if (wrt_en && hit_hex) begin
      hex_d = wdata[15:0];
    end
    if (wrt_en && hit_ledr) begin
      ledr_d = wdata[9:0];
    end
  end

  // Loads sample the current registers, so a same-cycle store is not visible yet.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      if (hit_hex) begin
        rdata_d = DBITS'(hex_q);
      end else if (hit_ledr) begin
        rdata_d = DBITS'(ledr_q);
      end else if (hit_key) begin
        rdata_d = DBITS'(key_stable_q);
      end else if (hit_sw) begin
        rdata_d = DBITS'(sw_stable_q);
      end else if (hit_kctrl) begin
        rdata_d = DBITS'(kctrl_q);
      end else begin
        rdata_d = '0;
      end
    end
  end

  assign rdata = rdata_q;
  assign LEDR  = ledr_q;
  assign HEX   = hex_q;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder: reset, store/load, debounce timing, sticky KCTRL,
// same-cycle collisions and asynchronous reset.
module tb_mmio_io_responder;

  localparam logic [31:0] AHex   = 32'hF0000000;
  localparam logic [31:0] ALedr  = 32'hF0000004;
  localparam logic [31:0] AKey   = 32'hF0000010;
  localparam logic [31:0] ASw    = 32'hF0000014;
  localparam logic [31:0] AKctrl = 32'hF0000110;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        wrt_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic        io_hit;
  logic [31:0] rdata;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic [15:0] HEX;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_io_responder dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wrt_en (wrt_en),
    .rd_en  (rd_en),
    .wdata  (wdata),
    .io_hit (io_hit),
    .rdata  (rdata),
    .KEY    (KEY),
    .SW     (SW),
    .LEDR   (LEDR),
    .HEX    (HEX)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    wdata  = d;
    wrt_en = 1'b1;
    tick();
    wrt_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; SW = 10'h3FF; KEY = 4'hF;
    addr = '0; wdata = '0; wrt_en = 1'b0; rd_en = 1'b0;
    #12;
    checks++; if (LEDR !== 10'h0) begin errors++; $display("FAIL reset_ledr: got %h expected 0", LEDR); end
    checks++; if (HEX !== 16'h0) begin errors++; $display("FAIL reset_hex: got %h expected 0", HEX); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    @(posedge clk); #1;
    reset = 1'b1;
    wait_cycles(18);
    addr = ASw; rd_en = 1'b1;
    tick();
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL sw_edge19_load: got %h expected 0", rdata); end
    tick();
    checks++; if (rdata !== 32'h3FF) begin errors++; $display("FAIL sw_after_reset: got %h expected 3ff", rdata); end
    rd_en = 1'b0;
  endtask

  task automatic test_store_load();
    logic [31:0] hits [5];
    hits[0] = AHex; hits[1] = ALedr; hits[2] = AKey; hits[3] = ASw; hits[4] = AKctrl;
    store(AHex, 32'hABCD1234);
    checks++; if (HEX !== 16'h1234) begin errors++; $display("FAIL hex_store: got %h expected 1234", HEX); end
    store(ALedr, 32'h5);
    checks++; if (LEDR !== 10'h5) begin errors++; $display("FAIL ledr_store: got %h expected 005", LEDR); end
    load(ALedr);
    checks++; if (rdata !== 32'h5) begin errors++; $display("FAIL ledr_load: got %h expected 5", rdata); end
    load(AHex);
    checks++; if (rdata !== 32'h1234) begin errors++; $display("FAIL hex_load: got %h expected 1234", rdata); end
    store(32'hF0000008, 32'h0);
    checks++; if (HEX !== 16'h1234) begin errors++; $display("FAIL nonhit_store: got %h expected 1234", HEX); end
    addr = 32'h0; #1;
    checks++; if (io_hit !== 1'b0) begin errors++; $display("FAIL io_hit_zero: got %b expected 0", io_hit); end
    load(32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL nonhit_load: got %h expected 0", rdata); end
    for (int i = 0; i < 5; i++) begin
      addr = hits[i]; #1;
      checks++;
      if (io_hit !== 1'b1) begin
        errors++; $display("FAIL io_hit_%0d: got %b expected 1", i, io_hit);
      end
    end
    addr = 32'hF0000008; #1;
    checks++; if (io_hit !== 1'b0) begin errors++; $display("FAIL io_hit_gap: got %b expected 0", io_hit); end
    tick();
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 10; i++) begin
      KEY[2] = i[0];
      tick();
    end
    KEY[2] = 1'b0;
    addr = AKey; rd_en = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      checks++;
      if (rdata !== 32'h0) begin
        errors++; $display("FAIL key_settling_edge%0d: got %h expected 0", k, rdata);
      end
    end
    tick();
    checks++; if (rdata !== 32'h4) begin errors++; $display("FAIL key2_stable: got %h expected 4", rdata); end
    rd_en = 1'b0;
    load(AKctrl);
    checks++; if (rdata !== 32'h4) begin errors++; $display("FAIL kctrl_key2: got %h expected 4", rdata); end
    KEY = 4'hF;
    wait_cycles(20);
    load(AKey);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL key2_release: got %h expected 0", rdata); end
    store(AKctrl, 32'hFF);
    load(AKctrl);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL kctrl_clear_all: got %h expected 0", rdata); end
  endtask

  task automatic test_sticky();
    for (int r = 0; r < 2; r++) begin
      KEY[0] = 1'b0;
      wait_cycles(20);
      KEY[0] = 1'b1;
      wait_cycles(20);
    end
    load(AKctrl);
    checks++; if (rdata !== 32'h11) begin errors++; $display("FAIL kctrl_overrun: got %h expected 11", rdata); end
    store(AKctrl, 32'h10);
    load(AKctrl);
    checks++; if (rdata !== 32'h01) begin errors++; $display("FAIL kctrl_w1c_ovr: got %h expected 01", rdata); end
    store(AKctrl, 32'h01);
    load(AKctrl);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL kctrl_w1c_press: got %h expected 0", rdata); end
  endtask

  task automatic test_simultaneous();
    KEY[1] = 1'b0;
    wait_cycles(18);
    // Press edge lands on edge 19, the same edge that ends this W1C store.
    store(AKctrl, 32'h02);
    load(AKctrl);
    checks++; if (rdata !== 32'h02) begin errors++; $display("FAIL set_beats_clear: got %h expected 02", rdata); end
    store(AKctrl, 32'h02);
    load(AKctrl);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL clear_bit1: got %h expected 0", rdata); end
    KEY = 4'hF;
    wait_cycles(20);
    store(ALedr, 32'h2);
    addr = ALedr; wdata = 32'h7; wrt_en = 1'b1; rd_en = 1'b1;
    tick();
    wrt_en = 1'b0; rd_en = 1'b0;
    checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL load_pre_store: got %h expected 2", rdata); end
    checks++; if (LEDR !== 10'h7) begin errors++; $display("FAIL ledr_after_collide: got %h expected 007", LEDR); end
  endtask

  task automatic test_reset_mid();
    store(AHex, 32'hFFFF);
    checks++; if (HEX !== 16'hFFFF) begin errors++; $display("FAIL hex_ffff: got %h expected ffff", HEX); end
    KEY[3] = 1'b0;
    wait_cycles(5);
    reset = 1'b0;
    #1;
    checks++; if (HEX !== 16'h0) begin errors++; $display("FAIL async_hex: got %h expected 0", HEX); end
    checks++; if (LEDR !== 10'h0) begin errors++; $display("FAIL async_ledr: got %h expected 0", LEDR); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL async_rdata: got %h expected 0", rdata); end
    @(posedge clk); #1;
    reset = 1'b1;
    wait_cycles(18);
    load(AKctrl);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL held_key_early: got %h expected 0", rdata); end
    load(AKctrl);
    checks++; if (rdata !== 32'h08) begin errors++; $display("FAIL held_key_press: got %h expected 08", rdata); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_debounce();
    test_sticky();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_io_responder.md
# mmio_io_responder

Memory-mapped I/O responder for the pipelined CPU's MEM stage: decodes CPU load/store accesses to the peripheral window and serves them from board I/O. It drives the HEX and LEDR outputs from CPU stores. It returns synchronized, debounced KEY and SW values plus a sticky key-press control register on CPU loads. It sits beside the data memory; the MEM-stage mux selects its read data when `io_hit` is high.

## Interface
Parameters:
- `DBITS`, 32, data/address width
- `ADDR_HEX`, 32'hF0000000, HEX output register (R/W)
- `ADDR_LEDR`, 32'hF0000004, LEDR output register (R/W)
- `ADDR_KEY`, 32'hF0000010, debounced key state (RO)
- `ADDR_SW`, 32'hF0000014, debounced switch state (RO)
- `ADDR_KCTRL`, 32'hF0000110, sticky key-press/overrun register (R/W1C)
- `DEBOUNCE_CYCLES`, 16, stable-sample count before a debounced bank updates (≥2)
- `CNT_BITS`, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1

Ports:
- `clk` in 1: sole clock; all state rises on posedge
- `reset` in 1: asynchronous, active-low reset
- `addr` in DBITS: MEM-stage byte address (ALU result)
- `wrt_en` in 1: store strobe
- `rd_en` in 1: load strobe
- `wdata` in DBITS: store data
- `io_hit` out 1: combinational; 1 when `addr` equals any of the five addresses
- `rdata` out DBITS: registered load data
- `KEY` in 4: raw push buttons, active-low, asynchronous
- `SW` in 10: raw switches, asynchronous
- `LEDR` out 10: LED register
- `HEX` out 16: hex display register (4 nibbles)

## Operation
- Sync: KEY and SW each pass through a two-flop synchronizer. The second-stage value is `s`.
- Debounce: each bank has its own candidate `c`, counter `n`, and stable value.
  - If `s != c`: load `c <= s` and `n <= 0`.
  - Else if `n < DEBOUNCE_CYCLES-1`: increment `n`.
  - Else: `stable <= c`, and `n` holds.
  - Any bounce restarts the count.
- Key stable value is stored inverted, so 1 means pressed.
- KCTRL[3:0] (press): bit i sets on a 0→1 transition of stable key i.
- KCTRL[7:4] (overrun): bit 4+i sets if that transition occurs while bit i is already 1.
- KCTRL[31:8] reads as 0.
- Stores:
  - ADDR_HEX: `HEX <= wdata[15:0]`.
  - ADDR_LEDR: `LEDR <= wdata[9:0]`.
  - ADDR_KCTRL: each 1 bit in `wdata[7:0]` clears the matching KCTRL bit.
  - ADDR_KEY, ADDR_SW, and non-hit addresses: no effect.
- Loads with `rd_en=1`: `rdata` is set on the next edge.
  - HEX and LEDR read zero-extended.
  - KEY returns {28'b0, stable keys}.
  - SW returns {22'b0, stable SW}.
  - KCTRL returns {24'b0, KCTRL}.
  - A non-hit address returns 0.
- When `rd_en=0`, `rdata` holds its previous value.
- Same-cycle set and W1C clear of one KCTRL bit: set wins.
- Same-cycle load and store to one address: load returns the pre-store value.

## Timing
- Reset (asynchronous assert, `reset`=0) clears the following to 0:
  - outputs `rdata`, `LEDR`, `HEX`
  - synchronizers, candidates, stable values, counters, KCTRL
- Reset value of the KEY synchronizers and candidates is "released" (raw 1).
- After deassert: a key held through reset produces a press edge, and sets KCTRL, DEBOUNCE_CYCLES+3 edges later.
- Pin-to-stable latency: a pin change settled before edge 1 appears in the stable value after edge DEBOUNCE_CYCLES+3. It therefore appears in `rdata` from a load issued in that cycle or later.
- Bounce: a glitch shorter than DEBOUNCE_CYCLES+1 cycles at `s` never reaches the stable value.
- Store latency: `LEDR`/`HEX`/KCTRL update at the edge ending the store cycle.
- Load latency: 1 cycle.
- `io_hit` has zero latency (pure decode of `addr`).
- Counter saturates at DEBOUNCE_CYCLES-1; there is no wrap.

## Test plan
- Reset: hold `reset`=0 with SW=10'h3FF and KEY=4'hF. Expect LEDR=0, HEX=0, rdata=0. Release reset, then load ADDR_SW after 19 cycles → rdata=32'h3FF.
- Store/load: store 32'hABCD1234 to ADDR_HEX → HEX=16'h1234. Store 32'h5 to ADDR_LEDR, then load it → rdata=32'h5 one cycle later. Load 32'h0 (non-hit) → io_hit=0, rdata=0.
- Debounce: drive KEY[2] low, toggling for 10 cycles, then hold low. ADDR_KEY reads 0 until 19 cycles after the final toggle, then reads 32'h4.
- Sticky press/overrun: press and release KEY0 twice without clearing → KCTRL=32'h11. Store 32'h10 to ADDR_KCTRL → KCTRL=32'h01. Store 32'h01 → 0.
- Simultaneous events: W1C bit 1 in the same cycle KEY1's press edge arrives → bit 1 remains set. A load plus a store of 32'h7 to ADDR_LEDR with LEDR=2 → rdata=2, then LEDR=7.
- Reset mid-operation: assert reset mid-debounce with HEX=16'hFFFF → HEX=0 immediately, with no clock edge needed.
